smi_mem_req_router: RTL and testbench
=====================================

Name: smi_mem_req_router

Overview:
Front-end request splitter for the SMI-to-AXI memory bridge. It sits upstream of the read and write AXI adaptors. It accepts one mixed SMI request stream and inspects the frame type identifier byte of each frame's first flit. Whole frames go to the read-request port or the write-request port; frames of unknown type are discarded. This lets both adaptors assume pre-filtered input.

Parameters:
FlitBytes, 8, SMI flit width in bytes; legal 8/16/32/64; DataWidth = FlitBytes*8.
DropCountWidth, 16, width of the saturating discarded-frame counter.

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
smiInReady  in  1  input flit valid
smiInEofc  in  8  0 = mid-frame; 1..FlitBytes = last flit, valid byte count
smiInData  in  DataWidth  input flit data; byte [7:0] of first flit = frame type
smiInStop  out  1  input backpressure
smiRdReady  out  1  read-request output flit valid
smiRdEofc  out  8  read-request output end-of-frame control
smiRdData  out  DataWidth  read-request output data
smiRdStop  in  1  read-request output backpressure
smiWrReady  out  1  write-request output flit valid
smiWrEofc  out  8  write-request output end-of-frame control
smiWrData  out  DataWidth  write-request output data
smiWrStop  in  1  write-request output backpressure
dropCount  out  DropCountWidth  discarded-frame count, saturating
dropPulse  out  1  one-cycle pulse when a discarded frame's last flit is consumed

Behaviour:
- Transfer rule: a flit moves on any SMI link when Ready=1 and Stop=0 in the same cycle.
- Reset (srst):
  - state = Idle.
  - smiRdReady, smiWrReady = 0; Eofc/Data outputs = 0.
  - dropCount = 0, dropPulse = 0.
  - smiInStop = 1 during the reset cycle.
- A reset mid-frame abandons the frame. The remaining input flits arrive in Idle and are classified as new frames; upstream must reset together with this block.
- Frame type constants: WRITE_REQ_ID = 8'h01, READ_REQ_ID = 8'h02. Any other value means Discard.
- Output stage: one registered flit slot per port (valid_q, eofc_q, data_q).
  - Slot "can load" when ~valid_q | ~outStop. Simultaneous drain and load are allowed, giving full throughput.
  - valid_q clears when drained with no load.
- State machine, states Idle / RouteRd / RouteWr / Discard:
  - Idle, smiInReady=1, type from smiInData[7:0]:
    - READ_REQ_ID: smiInStop = ~rdCanLoad. On transfer, load the read slot. If Eofc==0 go to RouteRd, else stay Idle (single-flit frame).
    - WRITE_REQ_ID: same as READ_REQ_ID, using the write slot and RouteWr.
    - Other: smiInStop = 0. The flit is consumed. If Eofc==0 go to Discard; else go to Idle and count the drop.
  - Idle, smiInReady=0: smiInStop = 0.
  - RouteRd / RouteWr: smiInStop = ~(target slot can load). Each transfer loads the target slot. A transfer with Eofc!=0 returns to Idle. The other port's slot keeps draining independently.
  - Discard: smiInStop = 0. Flits are dropped. A transfer with Eofc!=0 returns to Idle, increments dropCount and asserts dropPulse for 1 cycle.
- Latency: input transfer at cycle N gives output Ready=1 at cycle N+1. Data and Eofc pass unmodified; byte 0 of the first flit is retained.
- Frames are never interleaved on an output. Back-to-back frames of different type flow with no bubble when both slots can load.
- dropCount saturates at all-ones and does not wrap.
- Eofc > FlitBytes is treated as end-of-frame; no checking.
- Combinational path smiRdStop/smiWrStop -> smiInStop is accepted.

Decomposition:
- Package smi_frame_ids_pkg: WRITE_REQ_ID, READ_REQ_ID, READ_RESP_ID (8'hFD), WRITE_RESP_ID, router state encoding.
- One natural sub-module, smi_out_flit_reg (single-slot registered SMI output with can-load flag), instantiated for the read and write ports.

Test Plan:
- 3-flit frame, type 8'h02, Eofc 0,0,8, no stall -> identical flits on Rd port at cycles N+1..N+3; Wr port idle; dropCount=0.
- Single-flit frame type 8'h01, Eofc=5, then immediately a 2-flit type-8'h02 frame -> Wr flit at N+1, Rd flits at N+2,N+3; smiInStop never asserted.
- 4-flit frame type 8'h7F -> no output activity; smiInStop=0 throughout; dropPulse once on the 4th flit; dropCount=1.
- Rd frame with smiRdStop held high 5 cycles after the first flit -> smiInStop=1 while the slot is full; no flit lost or duplicated; order preserved after release.
- srst asserted during flit 2 of a 4-flit read frame -> next cycle all Ready=0, dropCount=0. Following flit 3 (data[7:0]=8'hAA) is classified as Discard.
- 65540 one-flit unknown frames with DropCountWidth=16 -> dropCount stops at 16'hFFFF.

Source files
------------

// File: rtl/smi_frame_ids_pkg.sv
// Shared SMI frame type identifiers and the request router's state encoding.
// Frame type lives in byte [7:0] of the first flit of every SMI frame.
// Imported by the router and its output-slot sub-module.
package smi_frame_ids_pkg;

    localparam logic [7:0] WRITE_REQ_ID  = 8'h01;
    localparam logic [7:0] READ_REQ_ID   = 8'h02;
    localparam logic [7:0] READ_RESP_ID  = 8'hFD;
    localparam logic [7:0] WRITE_RESP_ID = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ROUTE_RD = 2'd1,
        ST_ROUTE_WR = 2'd2,
        ST_DISCARD  = 2'd3
    } router_state_t;

    // Any non-zero end-of-frame control marks the last flit, including
    // out-of-range byte counts.
    function automatic logic smi_is_last(input logic [7:0] eofc);
        return (eofc != 8'd0);
    endfunction

endpackage

// File: rtl/smi_mem_req_router_if.sv
// One SMI flit link: Ready/Eofc/Data forward, Stop backward.
// A flit moves in any cycle where ready=1 and stop=0.
// master drives the flit, slave drives stop.
interface smi_mem_req_router_if #(
    parameter int DataWidth = 64
) ();

    logic                 ready;
    logic [7:0]           eofc;
    logic [DataWidth-1:0] data;
    logic                 stop;

    modport master (output ready, output eofc, output data, input stop);
    modport slave  (input ready, input eofc, input data, output stop);

endinterface

// File: rtl/smi_out_flit_reg.sv
// Single-slot registered SMI output with a can-load flag for the upstream router.
// Latency: one cycle from load to ready on the output link.
// Backpressure: can_load = empty or draining this cycle; drain and load may coincide.
module smi_out_flit_reg
    import smi_frame_ids_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_load,
    input  logic [7:0]             i_eofc,
    input  logic [DataWidth-1:0]   i_data,
    output logic                   o_can_load,
    smi_mem_req_router_if.master   smi_out
);

    logic                 r_valid;
    logic [7:0]           r_eofc;
    logic [DataWidth-1:0] r_data;

    assign o_can_load    = ~r_valid | ~smi_out.stop;
    assign smi_out.ready = r_valid;
    assign smi_out.eofc  = r_eofc;
    assign smi_out.data  = r_data;

    // Slot holds one flit; a load always wins, otherwise a drain empties it.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_valid <= 1'b0;
            r_eofc  <= 8'd0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_eofc  <= i_eofc;
            r_data  <= i_data;
        end else if (~smi_out.stop) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/smi_mem_req_router.sv
// Splits one SMI request stream into read and write request ports by frame type; unknown frames dropped.
// Latency: one cycle input-to-output through a registered slot per port.
// Backpressure: input stop follows the target slot's can-load; discarded flits are never stalled.
module smi_mem_req_router
    import smi_frame_ids_pkg::*;
#(
    parameter int FlitBytes      = 8,
    parameter int DropCountWidth = 16
) (
    input  logic                      clk,
    input  logic                      srst,
    smi_mem_req_router_if.slave       smiIn,
    smi_mem_req_router_if.master      smiRd,
    smi_mem_req_router_if.master      smiWr,
    output logic [DropCountWidth-1:0] dropCount,
    output logic                      dropPulse
);

    localparam int DataWidth = FlitBytes * 8;

    router_state_t             r_state;
    router_state_t             w_next_state;
    logic                      w_in_stop;
    logic                      w_xfer;
    logic                      w_last;
    logic [7:0]                w_type;
    logic                      w_rd_can;
    logic                      w_wr_can;
    logic                      w_rd_load;
    logic                      w_wr_load;
    logic                      w_drop_evt;
    logic [DropCountWidth-1:0] r_drop_count;
    logic                      r_drop_pulse;

    assign w_type      = smiIn.data[7:0];
    assign w_last      = smi_is_last(smiIn.eofc);
    assign w_xfer      = smiIn.ready & ~w_in_stop;
    assign smiIn.stop  = w_in_stop;
    assign dropCount   = r_drop_count;
    assign dropPulse   = r_drop_pulse;

    smi_out_flit_reg #(.DataWidth(DataWidth)) u_rd_slot (
        .clk        (clk),
        .srst       (srst),
        .i_load     (w_rd_load),
        .i_eofc     (smiIn.eofc),
        .i_data     (smiIn.data),
        .o_can_load (w_rd_can),
        .smi_out    (smiRd)
    );

    smi_out_flit_reg #(.DataWidth(DataWidth)) u_wr_slot (
        .clk        (clk),
        .srst       (srst),
        .i_load     (w_wr_load),
        .i_eofc     (smiIn.eofc),
        .i_data     (smiIn.data),
        .o_can_load (w_wr_can),
        .smi_out    (smiWr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (srst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Next state: first flit picks the route, a last-flit transfer returns to Idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !w_last) begin
                    if (w_type == READ_REQ_ID)       w_next_state = ST_ROUTE_RD;
                    else if (w_type == WRITE_REQ_ID) w_next_state = ST_ROUTE_WR;
                    else                             w_next_state = ST_DISCARD;
                end
            end
            ST_ROUTE_RD, ST_ROUTE_WR, ST_DISCARD: begin
                if (w_xfer && w_last) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: input stop, slot loads and the discarded-frame event.
    always_comb begin
        w_in_stop  = 1'b0;
        w_rd_load  = 1'b0;
        w_wr_load  = 1'b0;
        w_drop_evt = 1'b0;
        if (srst) begin
            w_in_stop = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (smiIn.ready) begin
                        if (w_type == READ_REQ_ID) begin
                            w_in_stop = ~w_rd_can;
                            w_rd_load = w_rd_can;
                        end else if (w_type == WRITE_REQ_ID) begin
                            w_in_stop = ~w_wr_can;
                            w_wr_load = w_wr_can;
                        end else begin
                            w_drop_evt = w_last;
                        end
                    end
                end
                ST_ROUTE_RD: begin
                    w_in_stop = ~w_rd_can;
                    w_rd_load = smiIn.ready & w_rd_can;
                end
                ST_ROUTE_WR: begin
                    w_in_stop = ~w_wr_can;
                    w_wr_load = smiIn.ready & w_wr_can;
                end
                ST_DISCARD: begin
                    w_drop_evt = smiIn.ready & w_last;
                end
                default: w_in_stop = 1'b0;
            endcase
        end
    end

    // Saturating discarded-frame counter and its one-cycle pulse.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_drop_count <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= w_drop_evt;
            if (w_drop_evt && !(&r_drop_count)) r_drop_count <= r_drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_smi_mem_req_router.sv
// Self-checking bench: directed frames, random mixed traffic with random output stalls,
// mid-frame reset and drop-counter saturation, all against a queue-based reference model.
module tb_smi_mem_req_router;
    import smi_frame_ids_pkg::*;

    localparam int DW = 64;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    smi_mem_req_router_if #(.DataWidth(DW)) in_if ();
    smi_mem_req_router_if #(.DataWidth(DW)) rd_if ();
    smi_mem_req_router_if #(.DataWidth(DW)) wr_if ();

    logic [15:0] drop_count;
    logic        drop_pulse;

    smi_mem_req_router #(.FlitBytes(8), .DropCountWidth(16)) dut (
        .clk       (clk),
        .srst      (srst),
        .smiIn     (in_if),
        .smiRd     (rd_if),
        .smiWr     (wr_if),
        .dropCount (drop_count),
        .dropPulse (drop_pulse)
    );

    typedef struct {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    // Reference model: each output port is a queue holding at most one flit;
    // dest is where the frame in progress goes (0 = no frame open, 1 rd, 2 wr, 3 dropped).
    flit_t       rd_q[$];
    flit_t       wr_q[$];
    int          dest;
    logic [15:0] m_cnt;
    logic        m_pulse;

    int vectors     = 0;
    int miscompares = 0;
    int rd_hold     = 0;
    bit rnd_stop    = 0;
    bit last_xfer   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          rd_can, wr_can, exp_stop, xfer;
        int          tgt;
        logic [7:0]  t;
        flit_t       f;
        if (rd_hold > 0) begin
            rd_if.stop = 1'b1;
            rd_hold--;
        end else begin
            rd_if.stop = rnd_stop ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        wr_if.stop = rnd_stop ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        rd_can   = (rd_q.size() == 0) || !rd_if.stop;
        wr_can   = (wr_q.size() == 0) || !wr_if.stop;
        exp_stop = 1'b0;
        tgt      = 0;
        if (srst) begin
            exp_stop = 1'b1;
        end else if (in_if.ready) begin
            if (dest == 0) begin
                t   = in_if.data[7:0];
                tgt = (t == 8'h02) ? 1 : (t == 8'h01) ? 2 : 3;
            end else begin
                tgt = dest;
            end
            if (tgt == 1) exp_stop = !rd_can;
            if (tgt == 2) exp_stop = !wr_can;
        end
        check("in_stop", 64'(in_if.stop), 64'(exp_stop));
        check("rd_ready", 64'(rd_if.ready), 64'(rd_q.size() != 0));
        check("wr_ready", 64'(wr_if.ready), 64'(wr_q.size() != 0));
        if (rd_q.size() != 0) begin
            check("rd_data", rd_if.data, rd_q[0].data);
            check("rd_eofc", 64'(rd_if.eofc), 64'(rd_q[0].eofc));
        end
        if (wr_q.size() != 0) begin
            check("wr_data", wr_if.data, wr_q[0].data);
            check("wr_eofc", 64'(wr_if.eofc), 64'(wr_q[0].eofc));
        end
        check("drop_count", 64'(drop_count), 64'(m_cnt));
        check("drop_pulse", 64'(drop_pulse), 64'(m_pulse));
        xfer = in_if.ready && !exp_stop;
        if (rd_q.size() != 0 && !rd_if.stop) void'(rd_q.pop_front());
        if (wr_q.size() != 0 && !wr_if.stop) void'(wr_q.pop_front());
        m_pulse = 1'b0;
        if (srst) begin
            rd_q.delete();
            wr_q.delete();
            dest  = 0;
            m_cnt = '0;
        end else if (xfer) begin
            f.eofc = in_if.eofc;
            f.data = in_if.data;
            if (tgt == 1) rd_q.push_back(f);
            if (tgt == 2) wr_q.push_back(f);
            if (in_if.eofc != 8'd0) begin
                dest = 0;
                if (tgt == 3) begin
                    m_pulse = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt++;
                end
            end else begin
                dest = tgt;
            end
        end
        last_xfer = xfer;
        @(posedge clk);
        #1;
    endtask

    task automatic send_flit(input logic [7:0] eofc, input logic [DW-1:0] data);
        int n = 0;
        in_if.ready = 1'b1;
        in_if.eofc  = eofc;
        in_if.data  = data;
        do begin
            cycle();
            n++;
        end while (!last_xfer && n < 200);
        if (!last_xfer) check("xfer_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [7:0] ftype, input int len, input logic [7:0] last_eofc,
                              input int gap);
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) d[7:0] = ftype;
            send_flit((i == len - 1) ? last_eofc : 8'd0, d);
        end
        in_if.ready = 1'b0;
        for (int g = 0; g < gap; g++) cycle();
    endtask

    task automatic drain();
        in_if.ready = 1'b0;
        rnd_stop    = 0;
        for (int i = 0; i < 4; i++) cycle();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [7:0]    ty;
        in_if.ready = 1'b0;
        in_if.eofc  = 8'd0;
        in_if.data  = '0;
        rd_if.stop  = 1'b0;
        wr_if.stop  = 1'b0;
        srst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        srst    = 1'b0;
        dest    = 0;
        m_cnt   = '0;
        m_pulse = 1'b0;
        check("rst_rd_data", rd_if.data, 64'd0);
        check("rst_rd_eofc", 64'(rd_if.eofc), 64'd0);
        check("rst_wr_data", wr_if.data, 64'd0);
        check("rst_wr_eofc", 64'(wr_if.eofc), 64'd0);
        cycle();

        // 3-flit read frame, no stall.
        send_frame(8'h02, 3, 8'd8, 0);
        drain();
        // Single-flit write frame straight into a 2-flit read frame.
        send_frame(8'h01, 1, 8'd5, 0);
        send_frame(8'h02, 2, 8'd8, 0);
        drain();
        // 4-flit unknown frame.
        send_frame(8'h7F, 4, 8'd8, 0);
        drain();
        check("drop_after_discard", 64'(drop_count), 64'd1);

        // Read frame with the read port stalled 5 cycles after the first flit.
        d = {$urandom, $urandom};
        d[7:0] = 8'h02;
        send_flit(8'd0, d);
        rd_hold = 5;
        send_flit(8'd0, {$urandom, $urandom});
        send_flit(8'd3, {$urandom, $urandom});
        drain();

        // Reset during flit 2 of a 4-flit read frame.
        d = {$urandom, $urandom};
        d[7:0] = 8'h02;
        send_flit(8'd0, d);
        in_if.ready = 1'b1;
        in_if.eofc  = 8'd0;
        in_if.data  = {$urandom, $urandom};
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        check("post_rst_rd_ready", 64'(rd_if.ready), 64'd0);
        check("post_rst_wr_ready", 64'(wr_if.ready), 64'd0);
        check("post_rst_count", 64'(drop_count), 64'd0);
        d = {$urandom, $urandom};
        d[7:0] = 8'hAA;
        send_flit(8'd0, d);
        send_flit(8'd8, {$urandom, $urandom});
        drain();
        check("post_rst_drop", 64'(drop_count), 64'd1);

        // Random mixed traffic with random output stalls.
        rnd_stop = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       ty = 8'h01;
                1:       ty = 8'h02;
                2:       ty = 8'h7F;
                default: ty = 8'($urandom);
            endcase
            send_frame(ty, $urandom_range(1, 4), 8'($urandom_range(1, 10)), $urandom_range(0, 2));
        end
        drain();

        // Drop counter saturation with one-flit unknown frames.
        in_if.ready = 1'b1;
        in_if.eofc  = 8'd1;
        in_if.data  = 64'hC3;
        for (int i = 0; i < 65540; i++) cycle();
        drain();
        check("drop_saturated", 64'(drop_count), 64'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
